// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   DATA_W       operand width (32)
//   ALU_*        ALU-control codes, shared with the ALU control block
//   mdu_state_t  sequencer states
//   magnitude()  absolute value of a two's-complement operand
package mdu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [3:0] ALU_MULT = 4'b1111;
  localparam logic [3:0] ALU_DIV  = 4'b1110;
  localparam logic [3:0] ALU_MFHI = 4'b0011;
  localparam logic [3:0] ALU_MFLO = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // 0x8000_0000 maps onto itself, which read as unsigned is the correct
  // magnitude 2^31.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value);
    return value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix -- combinational conditional two's-complement negate.
//   value   in  WIDTH  unsigned magnitude result
//   negate  in  1      1: return -value, 0: return value unchanged
//   result  out WIDTH  signed result
module mdu_sign_fix #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative signed 32-bit multiply / divide with HI/LO.
// Works on operand magnitudes for 32 radix-2 steps, then fixes the signs.
//   clk, rst_n   clock, asynchronous active-low reset
//   alu_ctrl     1111 mult, 1110 div, 0011 MFHI, 0100 MFLO (others ignored)
//   start        alu_ctrl / operands valid this cycle
//   rs_data      multiplicand or dividend (signed)
//   rt_data      multiplier or divisor (signed)
//   busy         stall request while an operation is in flight
//   done         one-cycle pulse when HI/LO hold a new result
//   hilo_data    HI or LO read data (0 when hilo_valid is low)
//   hilo_valid   hilo_data is valid this cycle
module mult_div_unit #(
  parameter int DATA_W = mdu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        alu_ctrl,
  input  logic              start,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hilo_data,
  output logic              hilo_valid
);

  import mdu_pkg::*;

  mdu_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] work;       // mult: {acc, multiplier}; div: {rem, quotient}
  logic [DATA_W-1:0]   operand_b;  // multiplicand or divisor magnitude
  logic                is_div;
  logic                sign_a;
  logic                sign_b;
  logic                div_zero;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;

  logic idle_or_done;
  logic accept;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign accept       = start && idle_or_done &&
                        ((alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_DIV));

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // One shift-add multiply step: add the multiplicand into the upper half
  // when the current multiplier bit is set, then shift the pair right.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;

  assign mul_sum  = {1'b0, work[2*DATA_W-1:DATA_W]} +
                    (work[0] ? {1'b0, operand_b} : '0);
  assign mul_next = {mul_sum, work[DATA_W-1:1]};

  // One restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The partial remainder is
  // always below twice the divisor, so 33 bits hold it and its trial result.
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] div_next;

  assign rem_shift = work[2*DATA_W-1:DATA_W-1];
  assign div_diff  = rem_shift - {1'b0, operand_b};
  assign div_next  = div_diff[DATA_W]
                   ? {rem_shift[DATA_W-1:0], work[DATA_W-2:0], 1'b0}
                   : {div_diff[DATA_W-1:0],  work[DATA_W-2:0], 1'b1};

  // Sign correction. The shared negator handles the 64-bit product, or the
  // quotient zero-extended; the remainder follows the dividend's sign.
  // A zero divisor leaves the dividend magnitude in the remainder, so the
  // remainder path already returns rs unchanged; only LO needs forcing.
  logic [2*DATA_W-1:0] fix_in;
  logic [2*DATA_W-1:0] fix_out;
  logic [DATA_W-1:0]   rem_signed;
  logic [DATA_W-1:0]   hi_result;
  logic [DATA_W-1:0]   lo_result;

  assign fix_in = is_div ? {{DATA_W{1'b0}}, work[DATA_W-1:0]} : work;

  mdu_sign_fix #(
    .WIDTH (2*DATA_W)
  ) u_sign_fix (
    .value  (fix_in),
    .negate (sign_a ^ sign_b),
    .result (fix_out)
  );

  assign rem_signed = sign_a ? (~work[2*DATA_W-1:DATA_W] + DATA_W'(1))
                             : work[2*DATA_W-1:DATA_W];
  assign hi_result  = is_div ? rem_signed : fix_out[2*DATA_W-1:DATA_W];
  assign lo_result  = (is_div && div_zero) ? '1 : fix_out[DATA_W-1:0];

  // HI/LO read port. Reads are refused while an operation is in flight so
  // the pipeline holds the instruction until the result is written.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    hilo_valid = 1'b0;
    hilo_data  = '0;
    if (rst_n && start && idle_or_done) begin
      if (alu_ctrl == ALU_MFHI) begin
        hilo_valid = 1'b1;
        hilo_data  = hi;
      end else if (alu_ctrl == ALU_MFLO) begin
        hilo_valid = 1'b1;
        hilo_data  = lo;
      end
    end
  end

  // Sequencer and datapath state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      operand_b <= '0;
      is_div    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            is_div   <= (alu_ctrl == ALU_DIV);
            sign_a   <= rs_data[DATA_W-1];
            sign_b   <= rt_data[DATA_W-1];
            div_zero <= (alu_ctrl == ALU_DIV) && (rt_data == '0);
            cnt      <= '0;
            if (alu_ctrl == ALU_DIV) begin
              work      <= {{DATA_W{1'b0}}, magnitude(rs_data)};
              operand_b <= magnitude(rt_data);
            end else begin
              work      <= {{DATA_W{1'b0}}, magnitude(rt_data)};
              operand_b <= magnitude(rs_data);
            end
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          work <= is_div ? div_next : mul_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W-1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= hi_result;
          lo    <= lo_result;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit -- self-checking bench for mult_div_unit.
// Expected results come from 64-bit integer arithmetic in the bench.
module tb_mult_div_unit;

  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  alu_ctrl;
  logic        start;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hilo_data;
  logic        hilo_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_ctrl   (alu_ctrl),
    .start      (start),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .busy       (busy),
    .done       (done),
    .hilo_data  (hilo_data),
    .hilo_valid (hilo_valid)
  );

  // Reference: signed 64-bit arithmetic; division truncates toward zero and
  // % takes the dividend's sign, matching the required HI/LO semantics.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      pa;
    longint      pb;
    logic [63:0] p;
    pa = $signed(a);
    pb = $signed(b);
    if (op == ALU_MULT) begin
      p  = 64'(pa * pb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (pb == 0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      hi = 32'(pa % pb);
      lo = 32'(pa / pb);
    end
  endfunction

  // Presents a start for one clock edge; returns #1 into cycle 1.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    alu_ctrl = op;
    rs_data  = a;
    rt_data  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    alu_ctrl = 4'h0;
  endtask

  // Counts cycles (sampled on the falling edge) until done; -1 on timeout.
  task automatic wait_done(output int cyc, output int gaps);
    cyc  = -1;
    gaps = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
      if (busy !== 1'b1) gaps++;
    end
  endtask

  // Issues MFHI then MFLO inside the current cycle and samples the read port.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo,
                           output logic vh, output logic vl);
    start    = 1'b1;
    alu_ctrl = ALU_MFHI;
    #1;
    hi       = hilo_data;
    vh       = hilo_valid;
    alu_ctrl = ALU_MFLO;
    #1;
    lo       = hilo_data;
    vl       = hilo_valid;
    start    = 1'b0;
    alu_ctrl = 4'h0;
  endtask

  // Checks one operation's latency, busy profile and result, read in the DONE cycle.
  task automatic finish_check(input string name, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo);
    int          cyc;
    int          gaps;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        vh;
    logic        vl;
    wait_done(cyc, gaps);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL %s latency: got %0d expected 34", name, cyc); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL %s busy: low in %0d calc cycles, expected 0", name, gaps); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done: got %b expected 0", name, busy); end
    read_hilo(hi, lo, vh, vl);
    checks++; if ({vh, vl} !== 2'b11) begin errors++; $display("FAIL %s hilo_valid: got %b%b expected 11", name, vh, vl); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s HI: got %h expected %h", name, hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s LO: got %h expected %h", name, lo, exp_lo); end
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    model(op, a, b, eh, el);
    launch(op, a, b);
    finish_check(name, eh, el);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] hi;
    logic [31:0] lo;
    logic        vh;
    logic        vl;
    rst_n = 1'b0; start = 1'b0; alu_ctrl = 4'h0; rs_data = '0; rt_data = '0;
    #1;
    checks++; if ({busy, done, hilo_valid} !== 3'b000) begin errors++; $display("FAIL reset outputs: got busy/done/valid=%b expected 000", {busy, done, hilo_valid}); end
    start = 1'b1; alu_ctrl = ALU_MFHI; #1;
    checks++; if ({hilo_valid, hilo_data} !== 33'd0) begin errors++; $display("FAIL reset read: got valid=%b data=%h expected 0/0", hilo_valid, hilo_data); end
    start = 1'b0; alu_ctrl = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_hilo(hi, lo, vh, vl);
    checks++; if ({vh, vl, hi, lo} !== {2'b11, 64'd0}) begin errors++; $display("FAIL reset hilo: got valid=%b%b hi=%h lo=%h expected 11/0/0", vh, vl, hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_ignored_code();
    start = 1'b1; alu_ctrl = 4'b0101; rs_data = 32'd9; rt_data = 32'd3;
    #1;
    checks++; if ({hilo_valid, hilo_data} !== 33'd0) begin errors++; $display("FAIL ignored_code read: got valid=%b data=%h expected 0/0", hilo_valid, hilo_data); end
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 4'h0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_code busy: got %b expected 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("mult_7_x_m3", ALU_MULT, 32'd7, 32'hFFFF_FFFD);
    run_op("div_m7_by_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div_5_by_0", ALU_DIV, 32'd5, 32'd0);
    run_op("div_neg_by_0", ALU_DIV, 32'h8000_0001, 32'd0);
    run_op("mult_min_x_min", ALU_MULT, 32'h8000_0000, 32'h8000_0000);
    run_op("div_7_by_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE);
  endtask

  task automatic test_random();
    logic [31:0] specials [5];
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    specials[0] = 32'h0000_0000; specials[1] = 32'h0000_0001; specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 1) == 0) ? ALU_MULT : ALU_DIV;
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 30);
      run_op($sformatf("rand%0d_%s_%h_%h", i, (op == ALU_MULT) ? "mult" : "div", a, b), op, a, b);
    end
  endtask

  // MFLO held from CALC cycle 5 must stall until DONE, then return the new LO.
  task automatic test_mflo_stall();
    logic [31:0] eh;
    logic [31:0] el;
    int          cyc;
    int          bad;
    cyc = -1;
    bad = 0;
    model(ALU_MULT, 32'h1234_5678, 32'hFEDC_BA98, eh, el);
    launch(ALU_MULT, 32'h1234_5678, 32'hFEDC_BA98);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start    = 1'b1;
        alu_ctrl = ALU_MFLO;
      end
      #1;
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
      if (c >= 5 && (hilo_valid !== 1'b0 || hilo_data !== 32'd0 || busy !== 1'b1)) bad++;
    end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL mflo_stall latency: got %0d expected 34", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mflo_stall hold: %0d cycles not stalled, expected 0", bad); end
    checks++; if (hilo_valid !== 1'b1) begin errors++; $display("FAIL mflo_stall valid: got %b expected 1", hilo_valid); end
    checks++; if (hilo_data !== el) begin errors++; $display("FAIL mflo_stall LO: got %h expected %h", hilo_data, el); end
    start = 1'b0; alu_ctrl = 4'h0;
    @(negedge clk);
  endtask

  // A div start during CALC must not disturb the mult in flight.
  task automatic test_ignored_start();
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        vh;
    logic        vl;
    int          cyc;
    int          gaps;
    model(ALU_MULT, 32'hFFFF_FF00, 32'd300, eh, el);
    launch(ALU_MULT, 32'hFFFF_FF00, 32'd300);
    repeat (10) @(negedge clk);
    start = 1'b1; alu_ctrl = ALU_DIV; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; alu_ctrl = 4'h0;
    wait_done(cyc, gaps);
    checks++; if (cyc !== 23) begin errors++; $display("FAIL ignored_start latency: got %0d more cycles expected 23", cyc); end
    read_hilo(hi, lo, vh, vl);
    checks++; if ({vh, vl, hi, lo} !== {2'b11, eh, el}) begin errors++; $display("FAIL ignored_start result: got %b%b %h_%h expected 11 %h_%h", vh, vl, hi, lo, eh, el); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi;
    logic [31:0] lo;
    logic        vh;
    logic        vl;
    int          pulses;
    pulses = 0;
    launch(ALU_MULT, 32'd12345, 32'hFFFF_0000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_mid outputs: got busy/done=%b expected 00", {busy, done}); end
    start = 1'b1; alu_ctrl = ALU_MFLO; #1;
    checks++; if ({hilo_valid, hilo_data} !== 33'd0) begin errors++; $display("FAIL reset_mid read: got valid=%b data=%h expected 0/0", hilo_valid, hilo_data); end
    start = 1'b0; alu_ctrl = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid aborted: %0d cycles with done/busy, expected 0", pulses); end
    read_hilo(hi, lo, vh, vl);
    checks++; if ({vh, vl, hi, lo} !== {2'b11, 64'd0}) begin errors++; $display("FAIL reset_mid hilo: got %b%b %h_%h expected 11 0_0", vh, vl, hi, lo); end
    @(negedge clk);
  endtask

  // Overflow divide, with a second op accepted in its DONE cycle.
  task automatic test_back_to_back();
    logic [31:0] eh;
    logic [31:0] el;
    model(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, eh, el);
    launch(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_check("div_overflow", eh, el);
    model(ALU_MULT, 32'hDEAD_BEEF, 32'h0000_1001, eh, el);
    launch(ALU_MULT, 32'hDEAD_BEEF, 32'h0000_1001);
    finish_check("back_to_back_mult", eh, el);
    model(ALU_DIV, 32'hFFFF_FF9C, 32'd7, eh, el);
    launch(ALU_DIV, 32'hFFFF_FF9C, 32'd7);
    finish_check("back_to_back_div", eh, el);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ignored_code();
    test_directed();
    test_mflo_stall();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
